output_wrapper: RTL and testbench

Result-side bus interface of the restoring divider. It captures the 16-bit Quotient and Remainder when the divider signals Done. It then serializes them as four bytes onto an 8-bit bus using a four-phase valid/accept handshake, mirroring the byte-wise loading done on the operand side. It sits between the divider core and the external byte-wide consumer.

---
 rtl/output_wrapper_if.sv | 40 ++++
 rtl/output_wrapper.sv | 85 ++++++++
 tb/tb_output_wrapper.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/output_wrapper_if.sv
// Result-side bus bundle between the divider core, the output wrapper and the byte-wide consumer.
// The slave modport is the wrapper's view; the master modport is the surrounding system's view.
interface output_wrapper_if #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] Quotient;
  logic [WORD_WIDTH-1:0] Remainder;
  logic                  Done;
  logic                  ReadyForResult;
  logic [DATA_WIDTH-1:0] DataOut;
  logic                  DataValid;
  logic                  DataAccept;
  logic                  LastByte;
  logic                  Overrun;

  modport slave (
    input  Quotient,
    input  Remainder,
    input  Done,
    input  DataAccept,
    output ReadyForResult,
    output DataOut,
    output DataValid,
    output LastByte,
    output Overrun
  );

  modport master (
    output Quotient,
    output Remainder,
    output Done,
    output DataAccept,
    input  ReadyForResult,
    input  DataOut,
    input  DataValid,
    input  LastByte,
    input  Overrun
  );
endinterface

// File: rtl/output_wrapper.sv
// Captures the divider's quotient/remainder on Done and serialises them MSB-first as bytes
// over a four-phase valid/accept handshake.
module output_wrapper #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 16
) (
  input logic            clk,
  input logic            reset,
  output_wrapper_if.slave bus
);
  localparam int RES_W = 2 * WORD_WIDTH;
  localparam int BYTES = RES_W / DATA_WIDTH;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEND    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]            state;
  logic [CNT_W-1:0]      byte_cnt;
  logic [RES_W-1:0]      shift_reg;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  last_byte;
  logic                  overrun;
  logic [RES_W-1:0]      captured;

  assign captured = {bus.Quotient, bus.Remainder};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      shift_reg <= '0;
      data_out  <= '0;
      last_byte <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // A result arriving while a transfer is still in flight is dropped and flagged.
      if (bus.Done && state != IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.Done) begin
            shift_reg <= captured;
            data_out  <= captured[RES_W-1 -: DATA_WIDTH];
            byte_cnt  <= '0;
            last_byte <= (BYTES == 1);
            state     <= SEND;
          end
        end
        SEND: begin
          if (bus.DataAccept) begin
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!bus.DataAccept) begin
            if (byte_cnt == LAST_CNT) begin
              last_byte <= 1'b0;
              state     <= IDLE;
            end else begin
              // Rotation keeps the upcoming byte just below the top of the register.
              data_out  <= shift_reg[RES_W-DATA_WIDTH-1 -: DATA_WIDTH];
              shift_reg <= {shift_reg[RES_W-DATA_WIDTH-1:0], shift_reg[RES_W-1 -: DATA_WIDTH]};
              byte_cnt  <= byte_cnt + 1'b1;
              last_byte <= ((byte_cnt + 1'b1) == LAST_CNT);
              state     <= SEND;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ReadyForResult = (state == IDLE);
  assign bus.DataValid      = (state == SEND);
  assign bus.DataOut        = data_out;
  assign bus.LastByte       = last_byte;
  assign bus.Overrun        = overrun;
endmodule

// File: tb/tb_output_wrapper.sv
// Self-checking bench for output_wrapper: table of results plus hand-written overrun,
// long-release and mid-transfer reset sequences, with expected bytes kept in a scoreboard.
module tb_output_wrapper;
  logic clk = 1'b0;
  logic reset;

  output_wrapper_if #(.DATA_WIDTH(8), .WORD_WIDTH(16)) bus ();

  output_wrapper #(.DATA_WIDTH(8), .WORD_WIDTH(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    int          base_delay;
    int          slow_idx;
    int          slow_delay;
    int          hold_idx;
    int          hold;
    int          inject_idx;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   vec_count   = 0;
  int   miscompares = 0;
  logic exp_overrun = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushExp(input logic [7:0] data, input logic last);
    exp_t e;
    e.data = data;
    e.last = last;
    sb.push_back(e);
  endtask

  // One-cycle Done pulse; the four expected bytes go into the scoreboard MSB first.
  task automatic applyStimulus(input logic [15:0] q, input logic [15:0] r);
    pushExp(q[15:8], 1'b0);
    pushExp(q[7:0],  1'b0);
    pushExp(r[15:8], 1'b0);
    pushExp(r[7:0],  1'b1);
    bus.Quotient  = q;
    bus.Remainder = r;
    bus.Done      = 1'b1;
    @(negedge clk);
    bus.Done = 1'b0;
  endtask

  task automatic consumeByte(input int delay, input int hold, input bit inject);
    exp_t       e;
    logic [7:0] held;
    int         n;
    n = 0;
    while (bus.DataValid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("data_valid", bus.DataValid, 1);
    checkOutput("sb_nonempty", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput("data_out", bus.DataOut, e.data);
      checkOutput("last_byte", bus.LastByte, e.last);
    end
    checkOutput("busy_ready", bus.ReadyForResult, 0);
    held = bus.DataOut;
    if (inject) begin
      bus.Quotient  = 16'h9999;
      bus.Remainder = 16'h9999;
      bus.Done      = 1'b1;
      @(negedge clk);
      bus.Done    = 1'b0;
      exp_overrun = 1'b1;
      checkOutput("overrun_set", bus.Overrun, 1);
      checkOutput("held_after_overrun", bus.DataOut, held);
    end
    repeat (delay) begin
      @(negedge clk);
      checkOutput("valid_held", bus.DataValid, 1);
      checkOutput("data_held", bus.DataOut, held);
    end
    bus.DataAccept = 1'b1;
    @(negedge clk);
    checkOutput("valid_drop", bus.DataValid, 0);
    repeat (hold) begin
      @(negedge clk);
      checkOutput("release_wait", bus.DataValid, 0);
      checkOutput("release_data", bus.DataOut, held);
    end
    bus.DataAccept = 1'b0;
    @(negedge clk);
  endtask

  task automatic consumeResult(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      consumeByte((i == v.slow_idx) ? v.slow_delay : v.base_delay,
                  (i == v.hold_idx) ? v.hold : 0,
                  (i == v.inject_idx));
    end
    checkOutput("ready_back", bus.ReadyForResult, 1);
    checkOutput("idle_valid", bus.DataValid, 0);
    checkOutput("idle_last", bus.LastByte, 0);
    checkOutput("overrun", bus.Overrun, exp_overrun);
    checkOutput("sb_drained", sb.size(), 0);
    repeat (3) @(negedge clk);
    checkOutput("no_extra_byte", bus.DataValid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    vecs[0] = '{16'h1234, 16'h0056, 1, -1, 0, -1, 0, -1};
    vecs[1] = '{16'hABCD, 16'hEF01, 1,  1, 5, -1, 0, -1};
    vecs[2] = '{16'h5AA5, 16'hC33C, 1, -1, 0,  0, 3, -1};
    vecs[3] = '{16'hFFFF, 16'h8000, 0, -1, 0, -1, 0, -1};
    vecs[4] = '{16'h2468, 16'h1357, 1, -1, 0, -1, 0,  1};
    vecs[5] = '{16'($urandom), 16'($urandom), 2, 3, 1, 2, 1, -1};

    reset          = 1'b0;
    bus.Done       = 1'b0;
    bus.DataAccept = 1'b0;
    bus.Quotient   = '0;
    bus.Remainder  = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", bus.ReadyForResult, 1);
    checkOutput("rst_valid", bus.DataValid, 0);

    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", bus.ReadyForResult, 1);
    checkOutput("idle_valid0", bus.DataValid, 0);
    checkOutput("idle_data", bus.DataOut, 8'h00);
    checkOutput("idle_overrun", bus.Overrun, 0);
    checkOutput("idle_last0", bus.LastByte, 0);

    bus.DataAccept = 1'b1;
    @(negedge clk);
    bus.DataAccept = 1'b0;
    checkOutput("accept_ignored", bus.DataValid, 0);

    for (int i = 0; i < 6; i++) begin
      $display("[TB] vector %0d: Q=%h R=%h", i, vecs[i].q, vecs[i].r);
      applyStimulus(vecs[i].q, vecs[i].r);
      consumeResult(vecs[i]);
    end

    $display("[TB] reset during third byte");
    applyStimulus(16'hFEDC, 16'hBA98);
    consumeByte(1, 0, 0);
    consumeByte(1, 0, 0);
    checkOutput("byte3_before_reset", bus.DataOut, 8'hBA);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_ready", bus.ReadyForResult, 1);
    checkOutput("async_valid", bus.DataValid, 0);
    checkOutput("async_data", bus.DataOut, 8'h00);
    checkOutput("async_last", bus.LastByte, 0);
    checkOutput("async_overrun", bus.Overrun, 0);
    exp_overrun = 1'b0;
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_ready", bus.ReadyForResult, 1);
    checkOutput("post_reset_valid", bus.DataValid, 0);
    v = '{16'h0001, 16'h0000, 1, -1, 0, -1, 0, -1};
    applyStimulus(v.q, v.r);
    consumeResult(v);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end
endmodule
